spell_mem_arbiter: RTL and testbench
====================================

# spell_mem_arbiter

Two-port arbiter that shares the single `spell_mem` access port between the SPELL execution core (CPU port) and the debug/loader engine (DBG port). It serialises requests, registers the winner's address, data and type onto the memory port, and returns read data with a one-cycle acknowledge. It sits between the core's fetch/store sequencer, the shift-register debug logic and `spell_mem`.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUSY cycles without `mem_data_ready` before abort (timeout build only); 8-bit, must be ≥1.

- `clk` in 1: single clock; everything samples on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU request; held high until `cpu_ack`.
- `cpu_addr` in 8: CPU address; stable while `cpu_req`.
- `cpu_wdata` in 8: CPU write data.
- `cpu_type_data` in 1: 1 = data memory, 0 = code memory.
- `cpu_write` in 1: 1 = write, 0 = read.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_err` out 1: qualifies `cpu_ack`; 1 = aborted by timeout.
- `cpu_rdata` out 8: read data, valid while `cpu_ack`.
- `dbg_req`, `dbg_addr`, `dbg_wdata`, `dbg_type_data`, `dbg_write`: DBG port inputs, same widths and meanings as the CPU port.
- `dbg_ack`, `dbg_err`, `dbg_rdata`: DBG port outputs, same widths and meanings as the CPU port.
- `mem_select` out 1: to `spell_mem` `select`.
- `mem_addr` out 8: to `spell_mem` `addr`.
- `mem_data_in` out 8: to `spell_mem` `data_in`.
- `mem_type_data` out 1: to `spell_mem` `memory_type_data`.
- `mem_write` out 1: to `spell_mem` `write`.
- `mem_data_out` in 8: from `spell_mem` `data_out`.
- `mem_data_ready` in 1: from `spell_mem` `data_ready`.
- `busy` out 1: high in every state except IDLE.
- `owner` out 1: 0 = CPU, 1 = DBG; the current or most recent grantee.

## Operation
- States: IDLE, BUSY, RESP. Encoding 2 bits; the fourth code returns to IDLE.
- **IDLE**
  - Samples `cpu_req` and `dbg_req`.
  - Only one request high: that port wins.
  - Both high: round-robin. The winner is the port not in `owner`, and `owner` updates to the winner.
  - Reset value of `owner` is 1, so the CPU wins the first tie.
  - On a grant, the winner's addr, wdata, type_data and write are latched into the `mem_*` registers, `mem_select` goes to 1, and the state moves to BUSY.
- **BUSY**
  - `mem_*` outputs stay constant; the request inputs are ignored.
  - `mem_data_ready` sampled high:
    - `rdata` ← `mem_data_out` for a read, 0x00 for a write.
    - `mem_select` ← 0 and `mem_write` ← 0.
    - The winner's ack ← 1 and state → RESP.
- **RESP**
  - The ack is high for exactly this cycle, then clears; state → IDLE.
  - RESP guarantees at least one cycle with `mem_select` low between transactions, which `spell_mem` needs to re-arm.
- Requester rule: drop `req`, or present a new request, on the edge where ack is high. IDLE treats a `req` that is still high as a new request.
- `cpu_rdata` and `dbg_rdata` both drive from one shared `rdata` register. Each is meaningful only alongside its own ack.
- The non-granted port waits with no ack; its request is served in the next IDLE cycle.

## Timing
- Reset, asynchronous on `rst_n` low:
  - State is IDLE.
  - All `mem_*` outputs, acks, errs and `rdata` are 0; `busy` is 0 and `owner` is 1.
  - An in-flight transaction is dropped with no ack.
  - Release is synchronous to the next edge.
- Latency:
  - `req` sampled at edge 0 → `mem_select` high from edge 0.
  - `mem_data_ready` sampled at edge k ≥ 1 → ack high for the cycle after edge k → IDLE at edge k+1.
  - Minimum request-to-ack latency is 2 edges. Back-to-back throughput is one transaction per 3 cycles minimum.
- `mem_data_ready` is ignored outside BUSY.
- A simultaneous `req` on the port just acked, while the other port is pending, goes to the other port (round-robin).

## Configuration
- `SPELL_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY and increments every BUSY cycle without `mem_data_ready`.
  - At `TIMEOUT_CYCLES`: `mem_select` and `mem_write` ← 0, `rdata` ← 0x00, the winner's ack and err ← 1, state → RESP.
  - Ready and timeout in the same cycle: ready wins, err = 0.
- `SPELL_ARB_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely; `cpu_err` and `dbg_err` are tied 0.

## Test plan
- CPU read, addr 0x12, type 0, `mem_data_ready` on the first BUSY edge with `mem_data_out` 0xA5:
  - `mem_select` is high for 1 cycle.
  - `cpu_ack` pulses once with `cpu_rdata` 0xA5 and `cpu_err` 0.
  - `dbg_ack` stays 0.
- DBG write, addr 0x40, wdata 0x3C, type 1:
  - `mem_addr`=0x40, `mem_data_in`=0x3C, `mem_type_data`=1, `mem_write`=1 throughout BUSY.
  - `dbg_ack` pulses with `dbg_rdata` 0x00.
- Both ports request continuously from reset with 3-cycle memory latency:
  - Grants alternate CPU, DBG, CPU, DBG.
  - `mem_select` is low for ≥1 cycle between grants.
- `rst_n` pulled low mid-BUSY, asynchronously between edges:
  - `mem_select` falls immediately and no ack is issued.
  - After release, a fresh CPU request completes normally.
- Timeout build with `TIMEOUT_CYCLES`=4 and `mem_data_ready` held 0: CPU ack with err 1 and rdata 0x00 after 4 BUSY cycles.
- Non-timeout build, same stimulus: no ack after 1000 cycles and `busy` stays 1.

Source files
------------

// File: rtl/spell_mem_arbiter.sv
// Round-robin arbiter sharing the spell_mem port between the CPU and DBG requesters.
// Optional BUSY watchdog: define SPELL_ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES.
module spell_mem_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_type_data,
    input  logic       cpu_write,
    output logic       cpu_ack,
    output logic       cpu_err,
    output logic [7:0] cpu_rdata,
    input  logic       dbg_req,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    input  logic       dbg_type_data,
    input  logic       dbg_write,
    output logic       dbg_ack,
    output logic       dbg_err,
    output logic [7:0] dbg_rdata,
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    output logic       mem_type_data,
    output logic       mem_write,
    input  logic [7:0] mem_data_out,
    input  logic       mem_data_ready,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic       owner_nxt;
    logic       sel_nxt;
    logic [7:0] addr_nxt;
    logic [7:0] wdata_nxt;
    logic       type_nxt;
    logic       write_nxt;
    logic [7:0] rdata, rdata_nxt;
    logic       cpu_ack_nxt, dbg_ack_nxt;
    logic       pick_dbg;

`ifdef SPELL_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt, tmo_cnt_nxt;
    logic       cpu_err_nxt, dbg_err_nxt;
`else
    logic       unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign cpu_err = 1'b0;
    assign dbg_err = 1'b0;
`endif

    // On a tie the port that did not win last time gets the grant
    assign pick_dbg = dbg_req & (~cpu_req | ~owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= 1'b1;
            mem_select    <= 1'b0;
            mem_addr      <= 8'h00;
            mem_data_in   <= 8'h00;
            mem_type_data <= 1'b0;
            mem_write     <= 1'b0;
            rdata         <= 8'h00;
            cpu_ack       <= 1'b0;
            dbg_ack       <= 1'b0;
`ifdef SPELL_ARB_TIMEOUT_EN
            tmo_cnt       <= 8'h00;
            cpu_err       <= 1'b0;
            dbg_err       <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            mem_select    <= sel_nxt;
            mem_addr      <= addr_nxt;
            mem_data_in   <= wdata_nxt;
            mem_type_data <= type_nxt;
            mem_write     <= write_nxt;
            rdata         <= rdata_nxt;
            cpu_ack       <= cpu_ack_nxt;
            dbg_ack       <= dbg_ack_nxt;
`ifdef SPELL_ARB_TIMEOUT_EN
            tmo_cnt       <= tmo_cnt_nxt;
            cpu_err       <= cpu_err_nxt;
            dbg_err       <= dbg_err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        sel_nxt     = mem_select;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_data_in;
        type_nxt    = mem_type_data;
        write_nxt   = mem_write;
        rdata_nxt   = rdata;
        cpu_ack_nxt = 1'b0;
        dbg_ack_nxt = 1'b0;
`ifdef SPELL_ARB_TIMEOUT_EN
        tmo_cnt_nxt = tmo_cnt;
        cpu_err_nxt = 1'b0;
        dbg_err_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_nxt = pick_dbg;
                    sel_nxt   = 1'b1;
                    addr_nxt  = pick_dbg ? dbg_addr      : cpu_addr;
                    wdata_nxt = pick_dbg ? dbg_wdata     : cpu_wdata;
                    type_nxt  = pick_dbg ? dbg_type_data : cpu_type_data;
                    write_nxt = pick_dbg ? dbg_write     : cpu_write;
                    state_nxt = BUSY;
`ifdef SPELL_ARB_TIMEOUT_EN
                    tmo_cnt_nxt = 8'h00;
`endif
                end
            end
            BUSY: begin
                if (mem_data_ready) begin
                    rdata_nxt   = mem_write ? 8'h00 : mem_data_out;
                    sel_nxt     = 1'b0;
                    write_nxt   = 1'b0;
                    cpu_ack_nxt = ~owner;
                    dbg_ack_nxt = owner;
                    state_nxt   = RESP;
                end
`ifdef SPELL_ARB_TIMEOUT_EN
                // Ready has priority, so a late response on the final cycle is not reported as an error
                else if (tmo_cnt == TIMEOUT_CYCLES - 8'd1) begin
                    rdata_nxt   = 8'h00;
                    sel_nxt     = 1'b0;
                    write_nxt   = 1'b0;
                    cpu_ack_nxt = ~owner;
                    dbg_ack_nxt = owner;
                    cpu_err_nxt = ~owner;
                    dbg_err_nxt = owner;
                    state_nxt   = RESP;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
`endif
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign cpu_rdata = rdata;
    assign dbg_rdata = rdata;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Scoreboard bench for spell_mem_arbiter: stimulus queues expected acks, a monitor pops and compares.
// A small memory model answers mem_select after a programmable latency with data addr ^ 8'hB7.
module tb_spell_mem_arbiter;

    typedef struct packed {
        logic       port;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cpu_req, cpu_type_data, cpu_write;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_ack, cpu_err;
    logic [7:0] cpu_rdata;
    logic       dbg_req, dbg_type_data, dbg_write;
    logic [7:0] dbg_addr, dbg_wdata;
    logic       dbg_ack, dbg_err;
    logic [7:0] dbg_rdata;
    logic       mem_select, mem_type_data, mem_write;
    logic [7:0] mem_addr, mem_data_in;
    logic [7:0] mem_data_out;
    logic       mem_data_ready;
    logic       busy, owner;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mem_lat  = 1;
    bit   mem_en   = 1'b1;

    spell_mem_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_type_data(cpu_type_data), .cpu_write(cpu_write),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_type_data(dbg_type_data), .dbg_write(dbg_write),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_type_data(mem_type_data), .mem_write(mem_write),
        .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready),
        .busy(busy), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: raise ready once select has been seen high for mem_lat negedges
    initial begin
        int lat_cnt;
        lat_cnt        = 0;
        mem_data_ready = 1'b0;
        mem_data_out   = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_select && mem_en) begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    mem_data_ready = 1'b1;
                    mem_data_out   = mem_addr ^ 8'hB7;
                end else begin
                    mem_data_ready = 1'b0;
                end
            end else begin
                lat_cnt        = 0;
                mem_data_ready = 1'b0;
            end
        end
    end

    // Monitor: every ack must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
                checkOutput("ack_exclusive", {7'd0, cpu_ack & dbg_ack}, 8'h00);
                checkOutput("ack_sel_low", {7'd0, mem_select}, 8'h00);
                if (exp_q.size() == 0) begin
                    checkOutput("ack_unexpected", {6'd0, dbg_ack, cpu_ack}, 8'h00);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ack_port", {7'd0, dbg_ack}, {7'd0, e.port});
                    checkOutput("ack_rdata", e.port ? dbg_rdata : cpu_rdata, e.rdata);
                    checkOutput("ack_err", {7'd0, e.port ? dbg_err : cpu_err}, {7'd0, e.err});
                end
            end
        end
    end

    task automatic applyStimulus(input bit port, input logic [7:0] addr, input logic [7:0] wdata,
                                 input bit tdata, input bit wr, input logic [7:0] exp_rd,
                                 input bit exp_err, output int sel_cycles, output int other_acks);
        bit done;
        exp_q.push_back('{port: port, rdata: exp_rd, err: exp_err});
        @(negedge clk);
        if (port) begin
            dbg_req = 1'b1; dbg_addr = addr; dbg_wdata = wdata; dbg_type_data = tdata; dbg_write = wr;
        end else begin
            cpu_req = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_type_data = tdata; cpu_write = wr;
        end
        sel_cycles = 0;
        other_acks = 0;
        done       = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #1;
            if (mem_select) begin
                sel_cycles++;
                checkOutput("busy_addr", mem_addr, addr);
                checkOutput("busy_wdata", mem_data_in, wdata);
                checkOutput("busy_type", {7'd0, mem_type_data}, {7'd0, tdata});
                checkOutput("busy_write", {7'd0, mem_write}, {7'd0, wr});
            end
            if (port ? cpu_ack : dbg_ack) other_acks++;
            if (port ? dbg_ack : cpu_ack) begin
                done = 1'b1;
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
        end
        if (!done) begin
            checkOutput("txn_timeout", 8'h00, 8'h01);
            cpu_req = 1'b0;
            dbg_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic runRoundRobin();
        exp_q.push_back('{port: 1'b0, rdata: 8'h96, err: 1'b0});
        exp_q.push_back('{port: 1'b1, rdata: 8'h00, err: 1'b0});
        exp_q.push_back('{port: 1'b0, rdata: 8'h96, err: 1'b0});
        exp_q.push_back('{port: 1'b1, rdata: 8'h00, err: 1'b0});
        mem_lat = 3;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 8'h21; cpu_wdata = 8'h00; cpu_type_data = 1'b0; cpu_write = 1'b0;
        dbg_req = 1'b1; dbg_addr = 8'h30; dbg_wdata = 8'h77; dbg_type_data = 1'b1; dbg_write = 1'b1;
        rst_n   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) break;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        checkOutput("rr_drain", 8'(exp_q.size()), 8'h00);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int sel, other, acks;
        rst_n = 1'b1;
        cpu_req = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00; cpu_type_data = 1'b0; cpu_write = 1'b0;
        dbg_req = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00; dbg_type_data = 1'b0; dbg_write = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_select", {7'd0, mem_select}, 8'h00);
        checkOutput("rst_addr", mem_addr, 8'h00);
        checkOutput("rst_data_in", mem_data_in, 8'h00);
        checkOutput("rst_type", {7'd0, mem_type_data}, 8'h00);
        checkOutput("rst_write", {7'd0, mem_write}, 8'h00);
        checkOutput("rst_acks", {6'd0, dbg_ack, cpu_ack}, 8'h00);
        checkOutput("rst_errs", {6'd0, dbg_err, cpu_err}, 8'h00);
        checkOutput("rst_rdata", cpu_rdata, 8'h00);
        checkOutput("rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("rst_owner", {7'd0, owner}, 8'h01);

        runRoundRobin();
        checkOutput("rr_owner", {7'd0, owner}, 8'h01);

        mem_lat = 1;
        applyStimulus(1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, sel, other);
        checkOutput("cpu_rd_sel_cycles", 8'(sel), 8'd1);
        checkOutput("cpu_rd_no_dbg_ack", 8'(other), 8'd0);
        checkOutput("cpu_rd_owner", {7'd0, owner}, 8'h00);

        mem_lat = 3;
        applyStimulus(1'b1, 8'h40, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b0, sel, other);
        checkOutput("dbg_wr_sel_cycles", 8'(sel), 8'd3);
        checkOutput("dbg_wr_no_cpu_ack", 8'(other), 8'd0);
        checkOutput("dbg_wr_owner", {7'd0, owner}, 8'h01);

        mem_en = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 8'h66; cpu_write = 1'b0; cpu_type_data = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_select", {7'd0, mem_select}, 8'h01);
        #1 rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        checkOutput("async_rst_select", {7'd0, mem_select}, 8'h00);
        checkOutput("async_rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("async_rst_owner", {7'd0, owner}, 8'h01);
        repeat (2) begin
            @(negedge clk);
            checkOutput("async_rst_no_ack", {6'd0, dbg_ack, cpu_ack}, 8'h00);
        end
        rst_n  = 1'b1;
        mem_en = 1'b1;
        mem_lat = 2;
        applyStimulus(1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 8'hE2, 1'b0, sel, other);
        checkOutput("post_rst_sel_cycles", 8'(sel), 8'd2);

        mem_en = 1'b0;
`ifdef SPELL_ARB_TIMEOUT_EN
        applyStimulus(1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, sel, other);
        checkOutput("tmo_sel_cycles", 8'(sel), 8'd4);
`else
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 8'h77; cpu_write = 1'b0; cpu_type_data = 1'b0;
        acks = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) acks++;
        end
        checkOutput("no_tmo_acks", 8'(acks), 8'd0);
        checkOutput("no_tmo_busy", {7'd0, busy}, 8'h01);
        checkOutput("no_tmo_select", {7'd0, mem_select}, 8'h01);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        mem_en = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("final_queue_empty", 8'(exp_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
